// File: rtl/l1_bus_interface_pkg.sv
// Shared cache/bus types: bus opcodes, snoop results, line geometry and the
// bus-interface FSM encoding.
package pkg_cache;

   typedef enum bit [1:0] {
      BUS_READ       = 2'd0,
      BUS_WRITE      = 2'd1,
      BUS_INVALIDATE = 2'd2,
      BUS_RFO        = 2'd3
   } bus_op_t;

   typedef enum bit [1:0] {
      NOHIT = 2'd0,
      HIT   = 2'd1,
      HITM  = 2'd2
   } snoop_result_t;

   localparam int LINE_OFFSET_BITS = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_SNOOP,
      ST_RESP
   } bus_state_t;

   // Encoding 2'b11 is reserved on the bus; treat it as a clean miss.
   function automatic logic [1:0] snoop_sanitize(input logic [1:0] r);
      return (r == 2'b11) ? 2'b00 : r;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/l1_bus_interface_fifo.sv
// l1_bus_fifo: synchronous request queue with push/pop, full and count.
// Push is refused when full even if a pop happens on the same edge.
module l1_bus_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 34
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [DATA_W-1:0]        wdata_i,
   input  logic                     pop_i,
   output logic [DATA_W-1:0]        rdata_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]    count_q;
   logic              empty, do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/l1_bus_interface.sv
// L1 bus interface: queues controller bus requests, issues them one at a time
// and returns completions with the snoop result. `L1_BUS_STATS_EN adds counters.
module l1_bus_interface
   import pkg_cache::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_op,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  bus_valid,
   output logic [1:0]            bus_op,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   input  logic                  bus_ack,
   input  logic                  snoop_valid,
   input  logic [1:0]            snoop_result,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [1:0]            rsp_op,
   output logic [ADDR_WIDTH-1:0] rsp_addr,
   output logic [1:0]            rsp_snoop
`ifdef L1_BUS_STATS_EN
   ,
   output logic [31:0]           stat_reads,
   output logic [31:0]           stat_writes,
   output logic [31:0]           stat_rfos,
   output logic [31:0]           stat_invals,
   output logic [31:0]           stat_hitm
`endif
);

   typedef struct packed {
      logic [1:0]            op;
      logic [ADDR_WIDTH-1:0] addr;
   } bus_req_t;

   bus_state_t state_q, state_d;
   bus_req_t   hold_q, hold_d, push_req, head_req;
   logic [1:0] snoop_q, snoop_d;
   logic       bus_valid_q, bus_valid_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic       fifo_full, fifo_pop, fifo_push;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic [$bits(bus_req_t)-1:0] fifo_rdata;
   logic       ack_fire, snoop_fire, hold_needs_snoop;

   assign push_req.op   = req_op;
   assign push_req.addr = {req_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
   assign fifo_push     = req_valid && req_ready;
   assign req_ready     = !fifo_full;
   assign head_req      = bus_req_t'(fifo_rdata);

   l1_bus_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W ($bits(bus_req_t))
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .wdata_i (push_req),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .count_o (fifo_count)
   );

   assign ack_fire         = (state_q == ST_ISSUE) && bus_ack;
   assign snoop_fire       = (state_q == ST_WAIT_SNOOP) && snoop_valid;
   assign hold_needs_snoop = (hold_q.op == BUS_READ) || (hold_q.op == BUS_RFO);

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      snoop_d     = snoop_q;
      bus_valid_d = bus_valid_q;
      rsp_valid_d = rsp_valid_q;
      fifo_pop    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fifo_count != '0) begin
               fifo_pop    = 1'b1;
               hold_d      = head_req;
               bus_valid_d = 1'b1;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus_ack) begin
               bus_valid_d = 1'b0;
               snoop_d     = NOHIT;
               if (hold_needs_snoop) begin
                  state_d = ST_WAIT_SNOOP;
               end else begin
                  rsp_valid_d = 1'b1;
                  state_d     = ST_RESP;
               end
            end
         end
         ST_WAIT_SNOOP: begin
            if (snoop_valid) begin
               snoop_d     = snoop_sanitize(snoop_result);
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         snoop_q     <= '0;
         bus_valid_q <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         snoop_q     <= snoop_d;
         bus_valid_q <= bus_valid_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // Bus and response fields share the holding register; only the valids differ.
   assign bus_valid = bus_valid_q;
   assign bus_op    = hold_q.op;
   assign bus_addr  = hold_q.addr;
   assign rsp_valid = rsp_valid_q;
   assign rsp_op    = hold_q.op;
   assign rsp_addr  = hold_q.addr;
   assign rsp_snoop = snoop_q;

`ifdef L1_BUS_STATS_EN
   logic [31:0] reads_q, writes_q, rfos_q, invals_q, hitm_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reads_q  <= '0;
         writes_q <= '0;
         rfos_q   <= '0;
         invals_q <= '0;
         hitm_q   <= '0;
      end else begin
         if (ack_fire && hold_q.op == BUS_READ)       reads_q  <= sat_inc32(reads_q);
         if (ack_fire && hold_q.op == BUS_WRITE)      writes_q <= sat_inc32(writes_q);
         if (ack_fire && hold_q.op == BUS_RFO)        rfos_q   <= sat_inc32(rfos_q);
         if (ack_fire && hold_q.op == BUS_INVALIDATE) invals_q <= sat_inc32(invals_q);
         if (snoop_fire && snoop_result == HITM)      hitm_q   <= sat_inc32(hitm_q);
      end
   end

   assign stat_reads  = reads_q;
   assign stat_writes = writes_q;
   assign stat_rfos   = rfos_q;
   assign stat_invals = invals_q;
   assign stat_hitm   = hitm_q;
`else
   logic stats_unused;
   assign stats_unused = ack_fire ^ snoop_fire;
`endif

endmodule

// File: tb/tb_l1_bus_interface.sv
// Scoreboard bench for l1_bus_interface: directed requests push expectations,
// bus/response monitors pop and compare; a responder plays the snoop side.
module tb_l1_bus_interface;
   import pkg_cache::*;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [1:0]    req_op = 2'd0;
   logic [AW-1:0] req_addr = '0;
   logic          bus_valid;
   logic [1:0]    bus_op;
   logic [AW-1:0] bus_addr;
   logic          bus_ack = 1'b0;
   logic          snoop_valid = 1'b0;
   logic [1:0]    snoop_result = 2'd0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [1:0]    rsp_op;
   logic [AW-1:0] rsp_addr;
   logic [1:0]    rsp_snoop;
`ifdef L1_BUS_STATS_EN
   logic [31:0]   stat_reads, stat_writes, stat_rfos, stat_invals, stat_hitm;
`endif

   always #5 clk = ~clk;

   l1_bus_interface #(.FIFO_DEPTH(4), .ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .bus_valid    (bus_valid),
      .bus_op       (bus_op),
      .bus_addr     (bus_addr),
      .bus_ack      (bus_ack),
      .snoop_valid  (snoop_valid),
      .snoop_result (snoop_result),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_op       (rsp_op),
      .rsp_addr     (rsp_addr),
      .rsp_snoop    (rsp_snoop)
`ifdef L1_BUS_STATS_EN
      ,
      .stat_reads   (stat_reads),
      .stat_writes  (stat_writes),
      .stat_rfos    (stat_rfos),
      .stat_invals  (stat_invals),
      .stat_hitm    (stat_hitm)
`endif
   );

   typedef struct { logic [1:0] op; logic [AW-1:0] addr; logic [1:0] snp; } exp_t;
   typedef struct { logic [1:0] v; int d; } plan_t;

   exp_t  exp_bus[$];
   exp_t  exp_rsp[$];
   plan_t snp_plan[$];
   int    n_chk = 0;
   int    n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic exp_add(input logic [1:0] op, input logic [AW-1:0] al, input logic [1:0] sv, input int sd);
      exp_t  e;
      plan_t p;
      e.op   = op;
      e.addr = al;
      e.snp  = 2'b00;
      if (op == BUS_READ || op == BUS_RFO) begin
         e.snp = (sv == 2'b11) ? 2'b00 : sv;
         p.v = sv;
         p.d = sd;
         snp_plan.push_back(p);
      end
      exp_bus.push_back(e);
      exp_rsp.push_back(e);
   endtask

   // Called just after a posedge; returns #1 after the acceptance edge.
   task automatic push(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] al,
                       input logic [1:0] sv, input int sd);
      int t;
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = a;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!req_ready && t < 200);
      if (!req_ready) begin
         chk("push_timeout", 64'd0, 64'd1);
         req_valid = 1'b0;
      end else begin
         @(posedge clk);
         exp_add(op, al, sv, sd);
         #1 req_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_rsp.size() != 0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("drain_pending", 64'(exp_rsp.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // Response monitor
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_rsp.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
         else begin
            e = exp_rsp.pop_front();
            chk("rsp_op", 64'(rsp_op), 64'(e.op));
            chk("rsp_addr", 64'(rsp_addr), 64'(e.addr));
            chk("rsp_snoop", 64'(rsp_snoop), 64'(e.snp));
         end
      end
   end

   // Bus command monitor
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n && bus_valid && bus_ack) begin
         if (exp_bus.size() == 0) chk("bus_unexpected", 64'd1, 64'd0);
         else begin
            e = exp_bus.pop_front();
            chk("bus_op", 64'(bus_op), 64'(e.op));
            chk("bus_addr", 64'(bus_addr), 64'(e.addr));
         end
      end
   end

   // Snoop responder: pulse the planned result d edges after the ack edge
   initial forever begin
      plan_t p;
      @(negedge clk);
      if (rst_n && bus_valid && bus_ack && (bus_op == BUS_READ || bus_op == BUS_RFO)) begin
         if (snp_plan.size() == 0) chk("snoop_plan_empty", 64'd1, 64'd0);
         else begin
            p = snp_plan.pop_front();
            repeat (p.d) @(posedge clk);
            #1 snoop_valid = 1'b1;
            snoop_result = p.v;
            @(posedge clk);
            #1 snoop_valid = 1'b0;
            snoop_result = 2'd0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic bad;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_bus_valid", 64'(bus_valid), 64'd0);
      chk("rst_bus_op", 64'(bus_op), 64'd0);
      chk("rst_bus_addr", 64'(bus_addr), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_op", 64'(rsp_op), 64'd0);
      chk("rst_rsp_addr", 64'(rsp_addr), 64'd0);
      chk("rst_rsp_snoop", 64'(rsp_snoop), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // READ with HIT two cycles after ack
      bus_ack = 1'b1;
      push(BUS_READ, 32'h1234_5678, 32'h1234_5640, HIT, 2);
      drain();

      // WRITE with ack tied high: rsp_valid after the 3rd edge
      push(BUS_WRITE, 32'h0000_00C0, 32'h0000_00C0, 2'd0, 0);
      @(negedge clk);
      chk("wr_rsp_after_E", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      chk("wr_bus_after_E1", 64'(bus_valid), 64'd1);
      chk("wr_rsp_after_E1", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      chk("wr_rsp_after_E2", 64'(rsp_valid), 64'd1);
      drain();

      // Reserved snoop encoding is captured as NOHIT
      push(BUS_RFO, 32'h0000_1FFF, 32'h0000_1FC0, 2'b11, 1);
      drain();

      // Fill while bus_ack is low: 5th push fills (one already popped)
      bus_ack = 1'b0;
      push(BUS_RFO,        32'h0000_1000, 32'h0000_1000, HITM,  1);
      push(BUS_READ,       32'h0000_2044, 32'h0000_2040, NOHIT, 3);
      push(BUS_WRITE,      32'h0000_30BF, 32'h0000_3080, 2'd0,  0);
      push(BUS_INVALIDATE, 32'h0000_4001, 32'h0000_4000, 2'd0,  0);
      chk("fill_ready_4", 64'(req_ready), 64'd1);
      push(BUS_READ,       32'h5555_5555, 32'h5555_5540, HIT,   1);
      @(negedge clk);
      chk("full_ready", 64'(req_ready), 64'd0);
      // A request held while full must not be taken
      @(posedge clk);
      #1 req_valid = 1'b1;
      req_op   = BUS_WRITE;
      req_addr = 32'hDEAD_0000;
      repeat (3) @(posedge clk);
      #1 req_valid = 1'b0;
      chk("full_ready_hold", 64'(req_ready), 64'd0);
      bus_ack = 1'b1;
      drain();

      // Push and pop on the same edge at count 2
      rsp_ready = 1'b0;
      push(BUS_WRITE,      32'h0000_6000, 32'h0000_6000, 2'd0, 0);
      push(BUS_WRITE,      32'h0000_7000, 32'h0000_7000, 2'd0, 0);
      push(BUS_INVALIDATE, 32'h0000_8000, 32'h0000_8000, 2'd0, 0);
      @(negedge clk);
      chk("pp_cnt_before", 64'(dut.fifo_count), 64'd2);
      chk("pp_in_resp", 64'(rsp_valid), 64'd1);
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b1;
      req_op   = BUS_WRITE;
      req_addr = 32'h0000_9010;
      exp_add(BUS_WRITE, 32'h0000_9000, 2'd0, 0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("pp_cnt_after", 64'(dut.fifo_count), 64'd2);
      chk("pp_issue", 64'(bus_valid), 64'd1);
      drain();

      // Nine back-to-back pushes across pointer wrap
      for (int i = 0; i < 9; i++) begin
         logic [1:0] op;
         op = 2'(i % 4);
         push(op, 32'hA000_003F | (32'(i) << 8), 32'hA000_0000 | (32'(i) << 8), 2'(i % 3), 1);
      end
      drain();

      // Reset mid-ISSUE with three entries queued
      bus_ack = 1'b0;
      push(BUS_WRITE, 32'h0001_0000, 32'h0001_0000, 2'd0, 0);
      push(BUS_WRITE, 32'h0002_0000, 32'h0002_0000, 2'd0, 0);
      push(BUS_WRITE, 32'h0003_0000, 32'h0003_0000, 2'd0, 0);
      push(BUS_WRITE, 32'h0004_0000, 32'h0004_0000, 2'd0, 0);
      @(negedge clk);
      chk("mid_issue_valid", 64'(bus_valid), 64'd1);
      chk("mid_issue_cnt", 64'(dut.fifo_count), 64'd3);
      @(posedge clk);
      #1 rst_n = 1'b0;
      exp_bus.delete();
      exp_rsp.delete();
      snp_plan.delete();
      #1;
      chk("mr_req_ready", 64'(req_ready), 64'd1);
      chk("mr_bus_valid", 64'(bus_valid), 64'd0);
      chk("mr_bus_op", 64'(bus_op), 64'd0);
      chk("mr_bus_addr", 64'(bus_addr), 64'd0);
      chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("mr_rsp_addr", 64'(rsp_addr), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      bus_ack = 1'b1;
      bad = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus_valid || rsp_valid) bad = 1'b1;
      end
      chk("no_issue_after_reset", 64'(bad), 64'd0);
      @(posedge clk);
      #1;

      // Traffic after reset; also exercises the optional counters
      push(BUS_RFO,  32'h0000_B000, 32'h0000_B000, HITM,  1);
      push(BUS_RFO,  32'h0000_C07F, 32'h0000_C040, HIT,   2);
      push(BUS_READ, 32'h0000_D001, 32'h0000_D000, NOHIT, 1);
      drain();
`ifdef L1_BUS_STATS_EN
      chk("stat_rfos", 64'(stat_rfos), 64'd2);
      chk("stat_reads", 64'(stat_reads), 64'd1);
      chk("stat_hitm", 64'(stat_hitm), 64'd1);
      chk("stat_writes", 64'(stat_writes), 64'd0);
      chk("stat_invals", 64'(stat_invals), 64'd0);
`endif

      repeat (4) @(negedge clk);
      chk("bus_queue_empty", 64'(exp_bus.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/l1_bus_interface.md
# l1_bus_interface

Downstream stage of the split L1 I/D cache controller. Accepts bus requests the controller produces on misses, write-allocates and evictions: READ, WRITE (writeback), RFO and INVALIDATE. Buffers them in a small FIFO, issues them one at a time on the shared L2/system bus and collects the snoop result. Returns a completion to the controller, which uses the snoop result to pick the MESI fill state (E on NOHIT, S on HIT/HITM).

## Interface
Parameters:
- `FIFO_DEPTH`, 4: request queue entries; power of two, 2..16.
- `ADDR_WIDTH`, 32: byte address width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  controller request valid.
- `req_ready`  out  1  queue can accept; equals !full.
- `req_op`  in  2  `bus_op_t`.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `bus_valid`  out  1  bus command valid.
- `bus_op`  out  2  `bus_op_t`.
- `bus_addr`  out  ADDR_WIDTH  line-aligned address, bits [5:0] = 0.
- `bus_ack`  in  1  bus accepted the command.
- `snoop_valid`  in  1  snoop result valid (single-cycle pulse).
- `snoop_result`  in  2  `snoop_result_t`.
- `rsp_valid`  out  1  completion valid.
- `rsp_ready`  in  1  controller consumes completion.
- `rsp_op`  out  2  op of completed request.
- `rsp_addr`  out  ADDR_WIDTH  line-aligned address of completed request.
- `rsp_snoop`  out  2  captured snoop result; NOHIT for WRITE/INVALIDATE.

## Operation
- Push when req_valid && req_ready. Push is blocked when the queue is full, even if a pop happens in the same cycle. Push and pop in the same cycle are legal when not full; count is unchanged.
- Request order is strict FIFO. Exactly one request is outstanding at a time.
- FSM states: IDLE, ISSUE, WAIT_SNOOP, RESP.
  - IDLE: when the queue is non-empty, pop the head into the holding register and go to ISSUE.
  - ISSUE: hold bus_valid=1 with stable bus_op/bus_addr until bus_ack. On ack, READ/RFO go to WAIT_SNOOP; WRITE/INVALIDATE go to RESP with snoop captured as NOHIT.
  - WAIT_SNOOP: on snoop_valid, capture snoop_result and go to RESP. Reserved encoding 2'b11 is captured as NOHIT.
  - RESP: hold rsp_valid=1 with stable rsp_* until rsp_ready, then go to IDLE.
- snoop_valid outside WAIT_SNOOP is ignored. bus_ack outside ISSUE is ignored.
- Address alignment happens on push: the low 6 bits are zeroed.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset (async assert, sync-safe deassert) values: req_ready=1, bus_valid=0, bus_op=0, bus_addr=0, rsp_valid=0, rsp_op=0, rsp_addr=0, rsp_snoop=0, FSM=IDLE, queue empty. Any outstanding or queued request is dropped.
- Request accepted at edge E with FSM IDLE and queue empty: bus_valid rises after edge E+1.
- Same-cycle bus_ack with bus_valid is allowed. Minimum WRITE turnaround: acceptance to rsp_valid in 3 edges.
- READ/RFO: rsp_valid rises the edge after snoop_valid is sampled.
- After rsp_ready, the next queued request's bus_valid rises 2 edges later (RESP→IDLE→ISSUE).
- All outputs are registered. There are no combinational input-to-output paths except req_ready, which is derived from registered count.

## Configuration
- `L1_BUS_STATS_EN`
  - Defined: adds 32-bit saturating counters `stat_reads`, `stat_writes`, `stat_rfos`, `stat_invals`, `stat_hitm` as outputs. Each increments on bus_ack for its op; `stat_hitm` increments on a captured HITM. All counters reset to 0.
  - Undefined: the counters and their ports are absent. Functional behaviour is identical.

## Structure
- `pkg_cache` gains:
  - `typedef enum bit [1:0] {BUS_READ=0, BUS_WRITE=1, BUS_INVALIDATE=2, BUS_RFO=3} bus_op_t`
  - `typedef enum bit [1:0] {NOHIT=0, HIT=1, HITM=2} snoop_result_t`
  - `LINE_OFFSET_BITS = 6`
- One sub-module, `l1_bus_fifo`: parameterised synchronous FIFO with push/pop/full/empty/count. The FSM and holding register live in the top.

## Test plan
- Reset mid-ISSUE with 3 entries queued: all outputs return to their reset values and req_ready=1; no bus_valid after release until a new push.
- READ 0x1234_5678 with snoop_result=HIT two cycles after ack: bus_addr=0x1234_5640 and rsp_snoop=HIT.
- WRITE 0x0000_00C0 with bus_ack tied high: rsp_valid rises 3 edges after acceptance and rsp_snoop=NOHIT.
- Fill with 4 requests (RFO, READ, WRITE, INVALIDATE) while bus_ack is held low: req_ready=0 after the 4th push, or the 5th with one already popped. Completions come out in push order.
- Push and pop in the same cycle at count=2: count stays 2. Pointer wrap after 9 sequential pushes keeps order intact.
- With L1_BUS_STATS_EN defined, 2 RFO (one HITM) and 1 READ: stat_rfos=2, stat_reads=1, stat_hitm=1.
